// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package rr_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
    onehot4 = N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rot_prio_enc4.sv
// Rotated 4-to-2 priority encoder: the search starts at ptr_i and wraps around.
module rot_prio_enc4
  import rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_req_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   rel;

  always_comb begin
    dbl = {req_i, req_i};
    rot = N_REQ'(dbl >> ptr_i);
    rel = '0;
    // Scan from the top so the lowest asserted index is the last one written.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[N_REQ-1-i]) rel = IDX_W'(N_REQ-1-i);
    end
    idx_o     = rel + ptr_i;
    any_req_o = |req_i;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for four requesters with a registered, held grant.
// Optional grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module rr_arbiter_4
`ifdef GRANT_TIMEOUT_EN
  #(parameter int unsigned MAX_HOLD = 8)
`endif
(
  input logic           clk,
  input logic           rst,
  rr_arbiter_4_if.slave bus
);
  import rr_arbiter_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] win_idx;
  logic             any_req;
  logic             release_req;
  logic             expired;
  logic             revoke;

  rot_prio_enc4 u_enc (
    .req_i     (bus.req),
    .ptr_i     (ptr_q),
    .idx_o     (win_idx),
    .any_req_o (any_req)
  );

  assign release_req = bus.done | ~bus.req[idx_q];

`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  assign expired = (state_q == ST_GRANT) && (hold_q == 8'(MAX_HOLD - 1));
  assign hold_d  = (state_q == ST_GRANT) ? hold_q + 8'd1 : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expired     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign revoke = release_req | expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_GRANT;
      ST_GRANT: if (revoke)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
`ifdef GRANT_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_d = onehot4(win_idx);
          idx_d   = win_idx;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (revoke) begin
          grant_d = '0;
          valid_d = 1'b0;
          ptr_d   = idx_q + 2'd1;
`ifdef GRANT_TIMEOUT_EN
          // A genuine release in the same cycle suppresses the watchdog pulse.
          timeout_d = expired & ~release_req;
`endif
        end
      end
      default: begin
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Self-checking bench for rr_arbiter_4 against a behavioural round-robin model.
module tb_rr_arbiter_4;

`ifdef GRANT_TIMEOUT_EN
  localparam int MAX_HOLD = 8;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter_4_if bus ();

`ifdef GRANT_TIMEOUT_EN
  rr_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  rr_arbiter_4 dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the resource, whose turn is first, how long it has been held.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_held;
  bit m_to;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_update(input logic [3:0] r, input logic d, input logic rs);
    bit found;
    m_to = 1'b0;
    if (rs) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
      m_held  = 0;
    end else if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (!found && r[(m_ptr + k) % 4]) begin
          found   = 1'b1;
          m_valid = 1'b1;
          m_idx   = (m_ptr + k) % 4;
          m_held  = 0;
        end
      end
    end else begin
      m_held++;
      if (d || !r[m_idx]) begin
        m_valid = 1'b0;
        m_ptr   = (m_idx + 1) % 4;
      end
`ifdef GRANT_TIMEOUT_EN
      else if (m_held == MAX_HOLD) begin
        m_valid = 1'b0;
        m_ptr   = (m_idx + 1) % 4;
        m_to    = 1'b1;
      end
`endif
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, compare.
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    logic [3:0] eg;
    bus.req = r;
    bus.done = d;
    rst = rs;
    @(posedge clk);
    model_update(r, d, rs);
    @(negedge clk);
    eg = m_valid ? (4'b0001 << m_idx) : 4'b0000;
    check_eq("grant", 32'(bus.grant), 32'(eg));
    check_eq("grant_valid", 32'(bus.grant_valid), 32'(m_valid));
    check_eq("grant_idx", 32'(bus.grant_idx), 32'(m_idx[1:0]));
    check_eq("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  logic [3:0] seq_exp [5];
  logic [3:0] r_prev;
  logic [3:0] r_cur;

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = '0;
    bus.done = 1'b0;
    m_valid  = 1'b0;
    m_idx    = 0;
    m_ptr    = 0;
    m_held   = 0;
    m_to     = 1'b0;
    @(negedge clk);

    step(4'b1111, 1'b1, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b0, 1'b0);
    check_eq("idle_valid", 32'(bus.grant_valid), 32'd0);

    // Full contention with done one cycle after each grant.
    seq_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 1'b0);
      check_eq("rr_seq", 32'(bus.grant), 32'(seq_exp[i]));
      step(4'b1111, 1'b1, 1'b0);
      check_eq("turnaround", 32'(bus.grant), 32'd0);
    end

    // Wrap order 2,3,0 after requester 1 releases.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    check_eq("wrap_idx", 32'(bus.grant_idx), 32'd0);
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    check_eq("wrap_next", 32'(bus.grant_idx), 32'd1);

    // Owner drops its request while another line raises.
    step(4'b0001, 1'b0, 1'b0);
    check_eq("drop_clear", 32'(bus.grant_valid), 32'd0);
    step(4'b0001, 1'b0, 1'b0);
    check_eq("drop_regrant", 32'(bus.grant), 32'b0001);

    // Reset in the middle of a grant.
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    check_eq("pre_rst", 32'(bus.grant), 32'b0100);
    step(4'b0100, 1'b0, 1'b1);
    check_eq("mid_rst", 32'(bus.grant), 32'd0);
    step(4'b1100, 1'b0, 1'b0);
    check_eq("post_rst", 32'(bus.grant_idx), 32'd2);

`ifdef GRANT_TIMEOUT_EN
    step(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < MAX_HOLD; i++) begin
      step(4'b0001, 1'b0, 1'b0);
      check_eq("hold_valid", 32'(bus.grant_valid), 32'd1);
    end
    step(4'b0001, 1'b0, 1'b0);
    check_eq("wd_pulse", 32'(bus.timeout), 32'd1);
    check_eq("wd_valid", 32'(bus.grant_valid), 32'd0);
    step(4'b0001, 1'b0, 1'b0);
    check_eq("wd_regrant", 32'(bus.grant), 32'b0001);
    check_eq("wd_single", 32'(bus.timeout), 32'd0);
`endif

    // Random traffic with sticky request patterns so grants last a while.
    step(4'b0000, 1'b0, 1'b1);
    r_prev = '0;
    for (int i = 0; i < 600; i++) begin
      r_cur  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : r_prev;
      r_prev = r_cur;
      step(r_cur, ($urandom_range(0, 5) == 0), ($urandom_range(0, 80) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
